cmp_hysteresis_alarm: RTL and testbench
=======================================

// Module: cmp_hysteresis_alarm
// PURPOSE
//   Downstream stage of the 32-bit magnitude comparator. Consumes its l/e/h flags, qualified by in_valid.
//   Raises a debounced "over-threshold" alarm after SET_CNT consecutive valid h samples.
//   Drops the alarm after CLR_CNT consecutive valid non-h samples.
//   Flags malformed (non-one-hot) flag samples with a sticky error.
// PARAMETERS
//   SET_CNT   4   consecutive valid h samples needed to assert alarm (legal 1..255)
//   CLR_CNT   3   consecutive valid l/e samples needed to deassert alarm (legal 1..255)
// PORTS
//   clk         in   1  single clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   clear       in   1  synchronous clear: FSM to IDLE, counters and err zeroed
//   in_valid    in   1  l/e/h valid this cycle; no backpressure, every valid cycle is consumed
//   l           in   1  comparator a<b
//   e           in   1  comparator a==b
//   h           in   1  comparator a>b
//   alarm       out  1  debounced alarm level (registered)
//   alarm_rise  out  1  one-cycle pulse, high in the first cycle alarm is 1
//   alarm_fall  out  1  one-cycle pulse, high in the first cycle alarm is 0 after being 1
//   err         out  1  sticky: set by a valid sample that is not exactly one-hot
//   state       out  2  current FSM state, for debug
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, run counter=0.
//     All outputs 0: alarm, alarm_rise, alarm_fall, err, state=2'd0.
//   Only cycles with in_valid=1 advance the FSM; with in_valid=0 the FSM and counter hold.
//   Sample classes, evaluated only when in_valid=1:
//     HI  = {l,e,h}==3'b001
//     LO  = {l,e,h}==3'b100 or 3'b010
//     BAD = anything else
//   A BAD sample sets err and leaves the FSM and counter unchanged.
//   States and transitions, where cnt is the run counter (8 bits):
//     IDLE(0):  HI -> ARM with cnt=1. If SET_CNT==1, go straight to ALARM instead.
//               LO -> stay.
//     ARM(1):   HI -> cnt++. When cnt+1==SET_CNT, go to ALARM with cnt=0.
//               LO -> IDLE with cnt=0. A broken run restarts from zero.
//     ALARM(2): LO -> CLR with cnt=1. If CLR_CNT==1, go straight to IDLE instead.
//               HI -> stay.
//     CLR(3):   LO -> cnt++. When cnt+1==CLR_CNT, go to IDLE with cnt=0.
//               HI -> ALARM with cnt=0.
//   alarm is 1 in ALARM and CLR, 0 in IDLE and ARM. It is decoded from the registered state.
//   Latency: alarm rises in the cycle after the edge that accepts the SET_CNT-th consecutive HI sample.
//   alarm_rise and alarm_fall: registered edge pulses aligned with alarm, each exactly 1 cycle wide.
//   clear=1 beats in_valid in the same cycle. Next cycle: state=IDLE, cnt=0, err=0, alarm=0.
//     If alarm was 1 when clear is applied, alarm_fall pulses.
//   Reset mid-run drops everything immediately; no pulse is produced on reset.
//   The counter never wraps: it is bounded by SET_CNT and CLR_CNT, both <=255.
// CONFIGURATION
//   HIT_COUNT_EN defined:
//     Adds output hit_count [15:0]: the number of valid HI samples accepted.
//     Saturates at 16'hFFFF.
//     Zeroed by rst_n and by clear.
//     Does not count HI samples arriving while clear=1.
//   HIT_COUNT_EN undefined: no port, no counter logic.
// STRUCTURE
//   Shared package cmp_pkg:
//     typedef enum logic [1:0] {IDLE, ARM, ALARM, CLR} alarm_state_t
//     localparam CNT_W = 8
//   Optional sub-module sat_counter #(W=16), instantiated only under HIT_COUNT_EN.
//     Inputs: inc, clr. Saturating.
//   Everything else lives in a single FSM plus edge-pulse register block.
// TESTING
//   Setup for all scenarios: SET_CNT=4, CLR_CNT=3.
//   1. 4 valid HI samples back to back -> state steps 1,1,1 then 2.
//      alarm=1 and alarm_rise=1 for exactly one cycle after the 4th sample.
//   2. HI,HI,HI,LO,HI,HI,HI -> alarm stays 0; state ends at ARM with cnt=3.
//   3. In ALARM: LO,LO,HI,LO,LO,LO -> alarm holds 1 through the HI.
//      alarm_fall pulses after the final LO; state ends at IDLE.
//   4. Valid {l,e,h}=3'b011 in ARM -> err=1 and sticky, cnt unchanged.
//      Then clear=1 with in_valid=1 and HI on the same cycle -> err=0, state=IDLE.
//   5. HI samples separated by in_valid=0 gaps of 5 cycles -> the gaps are ignored.
//      Alarm rises after the 4th valid HI.
//   6. rst_n pulled low while in CLR -> alarm=0 immediately, no alarm_fall pulse.
//      With HIT_COUNT_EN: 70000 HI samples -> hit_count=16'hFFFF.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the comparator alarm stage: FSM state encoding, sample classes, widths.
package cmp_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned HIT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ALARM = 2'd2,
    CLR   = 2'd3
  } alarm_state_t;

  typedef enum logic [1:0] {
    S_HI  = 2'd0,
    S_LO  = 2'd1,
    S_BAD = 2'd2
  } sample_t;

  // Only a one-hot {l,e,h} is a legal comparator result.
  function automatic sample_t classify(input logic [2:0] leh);
    sample_t s;
    case (leh)
      3'b001:         s = S_HI;
      3'b100, 3'b010: s = S_LO;
      default:        s = S_BAD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; exists only when HIT_COUNT_EN is defined.
`ifdef HIT_COUNT_EN
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/cmp_hysteresis_alarm.sv
// Debounced over-threshold alarm on comparator l/e/h flags, with sticky malformed-sample error.
// Optional HIT_COUNT_EN adds a saturating count of accepted HI samples (hit_count).
module cmp_hysteresis_alarm
  import cmp_pkg::*;
#(
  parameter int unsigned SET_CNT = 4,
  parameter int unsigned CLR_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  input  logic       l,
  input  logic       e,
  input  logic       h,
  output logic       alarm,
  output logic       alarm_rise,
  output logic       alarm_fall,
  output logic       err,
`ifdef HIT_COUNT_EN
  output logic [HIT_W-1:0] hit_count,
`endif
  output logic [1:0] state
);

  alarm_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             alarm_q, alarm_d;
  logic             alarm_rise_q, alarm_rise_d;
  logic             alarm_fall_q, alarm_fall_d;
  logic             err_q, err_d;
  sample_t          smp;
  logic             smp_hi, smp_lo, smp_bad;

  assign smp     = classify({l, e, h});
  assign smp_hi  = in_valid && (smp == S_HI);
  assign smp_lo  = in_valid && (smp == S_LO);
  assign smp_bad = in_valid && (smp == S_BAD);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alarm_q      <= 1'b0;
      alarm_rise_q <= 1'b0;
      alarm_fall_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alarm_q      <= alarm_d;
      alarm_rise_q <= alarm_rise_d;
      alarm_fall_q <= alarm_fall_d;
      err_q        <= err_d;
    end
  end

  // Run-length hysteresis; BAD and invalid cycles leave state and count untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (smp_hi || smp_lo) begin
      case (state_q)
        IDLE: begin
          if (smp_hi) begin
            if (SET_CNT == 1) begin
              state_d = ALARM;
              cnt_d   = '0;
            end else begin
              state_d = ARM;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ARM: begin
          if (smp_lo) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_W'(SET_CNT)) begin
            state_d = ALARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ALARM: begin
          if (smp_lo) begin
            if (CLR_CNT == 1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = CLR;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CLR: begin
          if (smp_hi) begin
            state_d = ALARM;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_W'(CLR_CNT)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Alarm and its edge pulses are registered from the next state so they align with state.
  always_comb begin
    alarm_d      = (state_d == ALARM) || (state_d == CLR);
    alarm_rise_d = alarm_d && !alarm_q;
    alarm_fall_d = !alarm_d && alarm_q;
    err_d        = err_q;
    if (clear) begin
      err_d = 1'b0;
    end else if (smp_bad) begin
      err_d = 1'b1;
    end
  end

  assign alarm      = alarm_q;
  assign alarm_rise = alarm_rise_q;
  assign alarm_fall = alarm_fall_q;
  assign err        = err_q;
  assign state      = state_q;

`ifdef HIT_COUNT_EN
  sat_counter #(
    .W(HIT_W)
  ) u_hit_count (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (smp_hi && !clear),
    .clr  (clear),
    .count(hit_count)
  );
`endif

endmodule

// File: tb/tb_cmp_hysteresis_alarm.sv
// Directed bench for cmp_hysteresis_alarm with SET_CNT=4, CLR_CNT=3.
// Observation vector is {state[1:0], alarm, alarm_rise, alarm_fall, err}.
module tb_cmp_hysteresis_alarm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       l, e, h;
  logic       alarm, alarm_rise, alarm_fall, err;
  logic [1:0] state;
`ifdef HIT_COUNT_EN
  logic [15:0] hit_count;
`endif
  logic [5:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  cmp_hysteresis_alarm #(
    .SET_CNT(4),
    .CLR_CNT(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .l         (l),
    .e         (e),
    .h         (h),
    .alarm     (alarm),
    .alarm_rise(alarm_rise),
    .alarm_fall(alarm_fall),
    .err       (err),
`ifdef HIT_COUNT_EN
    .hit_count (hit_count),
`endif
    .state     (state)
  );

  always #5 clk = ~clk;

  assign obs = {state, alarm, alarm_rise, alarm_fall, err};

  // Stimulus word: {clear, in_valid, l, e, h}; driven at negedge, outputs read 1 ns after posedge.
  task automatic apply(input logic [4:0] s);
    @(negedge clk);
    clear    = s[4];
    in_valid = s[3];
    {l, e, h} = s[2:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; {l, e, h} = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 6'b00_0000) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected %b", obs, 6'b00_0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(5'b0_0_000);
    n_checks++;
    if (obs !== 6'b00_0000) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", obs, 6'b00_0000);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] stim [5] = '{5'b0_1_001, 5'b0_1_001, 5'b0_1_001, 5'b0_1_001, 5'b0_0_000};
    logic [5:0] expv [5] = '{6'b01_0000, 6'b01_0000, 6'b01_0000, 6'b10_1100, 6'b10_1000};
    for (int i = 0; i < 5; i++) begin
      apply(stim[i]);
      n_checks++;
      if (obs !== expv[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_broken_run();
    logic [4:0] stim [9] = '{5'b1_0_000, 5'b0_1_001, 5'b0_1_001, 5'b0_1_001, 5'b0_1_100,
                            5'b0_1_001, 5'b0_1_001, 5'b0_1_001, 5'b0_1_001};
    logic [5:0] expv [9] = '{6'b00_0010, 6'b01_0000, 6'b01_0000, 6'b01_0000, 6'b00_0000,
                            6'b01_0000, 6'b01_0000, 6'b01_0000, 6'b10_1100};
    for (int i = 0; i < 9; i++) begin
      apply(stim[i]);
      n_checks++;
      if (obs !== expv[i]) begin
        n_fail++;
        $display("FAIL broken_run[%0d]: got %b expected %b", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_clear_run();
    logic [4:0] stim [7] = '{5'b0_1_100, 5'b0_1_010, 5'b0_1_001, 5'b0_1_100,
                            5'b0_1_010, 5'b0_1_100, 5'b0_0_000};
    logic [5:0] expv [7] = '{6'b11_1000, 6'b11_1000, 6'b10_1000, 6'b11_1000,
                            6'b11_1000, 6'b00_0010, 6'b00_0000};
    for (int i = 0; i < 7; i++) begin
      apply(stim[i]);
      n_checks++;
      if (obs !== expv[i]) begin
        n_fail++;
        $display("FAIL clear_run[%0d]: got %b expected %b", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_bad_sample();
    logic [4:0] stim [12] = '{5'b0_1_001, 5'b0_1_001, 5'b0_1_011, 5'b0_0_111, 5'b0_1_001,
                             5'b1_1_001, 5'b0_1_001, 5'b0_1_001, 5'b0_1_001, 5'b0_1_000,
                             5'b0_1_001, 5'b1_0_000};
    logic [5:0] expv [12] = '{6'b01_0000, 6'b01_0000, 6'b01_0001, 6'b01_0001, 6'b01_0001,
                             6'b00_0000, 6'b01_0000, 6'b01_0000, 6'b01_0000, 6'b01_0001,
                             6'b10_1101, 6'b00_0010};
    for (int i = 0; i < 12; i++) begin
      apply(stim[i]);
      n_checks++;
      if (obs !== expv[i]) begin
        n_fail++;
        $display("FAIL bad_sample[%0d]: got %b expected %b", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [5:0] exp_hi;
    logic [5:0] exp_gap;
    for (int k = 0; k < 4; k++) begin
      exp_hi  = (k < 3) ? 6'b01_0000 : 6'b10_1100;
      exp_gap = (k < 3) ? 6'b01_0000 : 6'b10_1000;
      apply(5'b0_1_001);
      n_checks++;
      if (obs !== exp_hi) begin
        n_fail++;
        $display("FAIL gaps_hi[%0d]: got %b expected %b", k, obs, exp_hi);
      end
      for (int g = 0; g < 5; g++) begin
        apply((g % 2 == 0) ? 5'b0_0_111 : 5'b0_0_001);
        n_checks++;
        if (obs !== exp_gap) begin
          n_fail++;
          $display("FAIL gaps_idle[%0d.%0d]: got %b expected %b", k, g, obs, exp_gap);
        end
      end
    end
  endtask

  task automatic test_reset_in_clr();
    apply(5'b0_1_100);
    n_checks++;
    if (obs !== 6'b11_1000) begin
      n_fail++;
      $display("FAIL rst_clr_enter: got %b expected %b", obs, 6'b11_1000);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 6'b00_0000) begin
      n_fail++;
      $display("FAIL rst_clr_async: got %b expected %b", obs, 6'b00_0000);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 6'b00_0000) begin
      n_fail++;
      $display("FAIL rst_clr_hold: got %b expected %b", obs, 6'b00_0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(5'b0_0_000);
    n_checks++;
    if (obs !== 6'b00_0000) begin
      n_fail++;
      $display("FAIL rst_clr_after: got %b expected %b", obs, 6'b00_0000);
    end
  endtask

`ifdef HIT_COUNT_EN
  task automatic test_hit_count();
    logic [15:0] expc;
    apply(5'b1_0_000);
    repeat (3) apply(5'b0_1_001);
    apply(5'b0_1_100);
    apply(5'b0_0_001);
    expc = 16'd3;
    n_checks++;
    if (hit_count !== expc) begin
      n_fail++;
      $display("FAIL hit_small: got %h expected %h", hit_count, expc);
    end
    apply(5'b1_1_001);
    expc = 16'd0;
    n_checks++;
    if (hit_count !== expc) begin
      n_fail++;
      $display("FAIL hit_clear: got %h expected %h", hit_count, expc);
    end
    for (int i = 0; i < 70000; i++) apply(5'b0_1_001);
    expc = 16'hFFFF;
    n_checks++;
    if (hit_count !== expc) begin
      n_fail++;
      $display("FAIL hit_saturate: got %h expected %h", hit_count, expc);
    end
    apply(5'b1_0_000);
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_broken_run();
    test_clear_run();
    test_bad_sample();
    test_gaps();
    test_reset_in_clr();
`ifdef HIT_COUNT_EN
    test_hit_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
